// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and sizing helper for the digit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the digit counter: clog2(n/digit), never narrower than one bit
    function automatic int cnt_width(input int n, input int digit);
        int w;
        w = $clog2(n / digit);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// rtl/serial_sub_digit.sv - combinational DIGIT-bit add/subtract slice (module sub_digit_slice)
module sub_digit_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    input  logic             invert_b,
    output logic [DIGIT-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    // Ripple through the slice, remembering the carry entering the top bit for overflow detection
    always_comb begin
        logic c;
        logic bb;
        sum      = '0;
        c_msb_in = 1'b0;
        c        = c_in;
        for (int i = 0; i < DIGIT; i++) begin
            bb = b[i] ^ invert_b;
            if (i == DIGIT - 1) begin
                c_msb_in = c;
            end
            sum[i] = a[i] ^ bb ^ c;
            c      = (a[i] & bb) | (a[i] & c) | (bb & c);
        end
        c_out = c;
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial x - y - B_in with valid/ready handshakes; SERIAL_SUB_ADD_MODE_EN adds op port for add mode
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N     = 8,
    parameter int DIGIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         B_in,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic         op,
`endif
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         B_out,
    output logic         overflow
);

    generate
        if ((DIGIT < 1) || (DIGIT > N) || ((N % DIGIT) != 0)) begin : g_param_err
            $error("serial_subtractor: N must be a multiple of DIGIT and 1 <= DIGIT <= N");
        end
    endgenerate

    localparam int            NUM_DIGITS = N / DIGIT;
    localparam int            CW         = cnt_width(N, DIGIT);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  y_q, y_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bout_q, bout_d;
    logic          ovf_q, ovf_d;
    logic          add_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic          add_d;
`endif

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] s_dig;
    logic             c_out;
    logic             c_msb_in;

    // Select the operand digits for the current step
    always_comb begin
        a_dig = x_q[cnt_q * DIGIT +: DIGIT];
        b_dig = y_q[cnt_q * DIGIT +: DIGIT];
    end

    sub_digit_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a        (a_dig),
        .b        (b_dig),
        .c_in     (carry_q),
        .invert_b (~add_q),
        .sum      (s_dig),
        .c_out    (c_out),
        .c_msb_in (c_msb_in)
    );

    // Handshakes: in_ready is forced low while reset is held
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign B_out     = bout_q;
    assign overflow  = ovf_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_q   <= 1'b0;
`endif
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_q   <= add_d;
`endif
        end
    end

`ifndef SERIAL_SUB_ADD_MODE_EN
    assign add_q = 1'b0;
`endif

    // Next-state and datapath updates: capture at accept, one digit per RUN cycle, hold in DONE
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
        add_d   = add_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    x_d     = x;
                    y_d     = y;
                    diff_d  = '0;
                    bout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                    add_d   = op;
                    carry_d = op ? B_in : ~B_in;
`else
                    carry_d = ~B_in;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[cnt_q * DIGIT +: DIGIT] = s_dig;
                carry_d = c_out;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_DIGIT) begin
                    // Subtraction reports borrow as the inverted carry; addition reports raw carry
                    bout_d  = add_q ? c_out : ~c_out;
                    ovf_d   = c_msb_in ^ c_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int N     = 8;
    localparam int DIGIT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         B_in = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic         op = 1'b0;
`endif
    logic [N-1:0] x = '0;
    logic [N-1:0] y = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] diff;
    logic         B_out;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N+1:0] exp_q[$];

    serial_subtractor #(.N(N), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .B_in      (B_in),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .op        (op),
`endif
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .B_out     (B_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: {diff, B_out, overflow} from plain integer arithmetic
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic bin, input logic opv);
        longint ua, ub, sa, sb, r, sr, cb;
        logic [N-1:0] d;
        logic bo, ov;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        cb = bin;
        if (opv) begin
            r  = ua + ub + cb;
            sr = sa + sb + cb;
            bo = (r >= (longint'(1) << N));
        end else begin
            r  = ua - ub - cb;
            sr = sa - sb - cb;
            bo = (r < 0);
        end
        d  = r[N-1:0];
        ov = (sr > ((longint'(1) << (N - 1)) - 1)) || (sr < -(longint'(1) << (N - 1)));
        return {d, bo, ov};
    endfunction

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                         input logic opv, input int hold, input logic toggle);
        int lat;
        logic [N+1:0] exp_v, got, first;
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
        end
        x = a; y = b; B_in = bin;
`ifdef SERIAL_SUB_ADD_MODE_EN
        op = opv;
`endif
        in_valid = 1'b1;
        exp_q.push_back(model(a, b, bin, opv));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (toggle) begin
                x = N'($urandom); y = N'($urandom); B_in = 1'($urandom);
            end
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (lat != N / DIGIT || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles out_valid=%b required %0d cycles", lat, out_valid, N / DIGIT);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_ready_while_valid: in_ready=%b required 0", in_ready);
        end
        first = {diff, B_out, overflow};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({diff, B_out, overflow} !== first || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stable: res=%h in_ready=%b out_valid=%b required res=%h in_ready=0 out_valid=1",
                         {diff, B_out, overflow}, in_ready, out_valid, first);
            end
        end
        exp_v = exp_q.pop_front();
        got   = {diff, B_out, overflow};
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL result %h-%h-%b op=%b: diff=%h B_out=%b ovf=%b required diff=%h B_out=%b ovf=%b",
                     a, b, bin, opv, got[N+1:2], got[1], got[0], exp_v[N+1:2], exp_v[1], exp_v[0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL out_valid_drop: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({in_ready, out_valid, diff, B_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {in_ready, out_valid, diff, B_out, overflow});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        do_op(8'h05, 8'h03, 1'b0, 1'b0, 0, 1'b0);
        do_op(8'h03, 8'h05, 1'b0, 1'b0, 0, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        do_op(8'h7F, 8'hFF, 1'b0, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_op(8'h05, 8'h03, 1'b0, 1'b0, 3, 1'b1);
        do_op(8'h80, 8'h01, 1'b0, 1'b0, 3, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        x = 8'h55; y = 8'h22; B_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, diff, B_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %h required 0", {in_ready, out_valid, diff, B_out, overflow});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL discarded_result: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        do_op(8'h10, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            do_op(N'($urandom), N'($urandom), 1'($urandom), 1'b0, 0, 1'b0);
        end
    endtask

`ifdef SERIAL_SUB_ADD_MODE_EN
    task automatic test_add_mode();
        do_op(8'h7F, 8'h01, 1'b0, 1'b1, 0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b1, 0, 1'b0);
        do_op(8'h12, 8'h34, 1'b1, 1'b1, 0, 1'b0);
        do_op(8'h05, 8'h03, 1'b0, 1'b0, 0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_SUB_ADD_MODE_EN
        test_add_mode();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
